inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter NOP_INSTR, default 32'h0000_0000, SHALL be the bubble instruction driven on InstrD when ValidD is 0.
REQ-002 clock  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 PCF  input  32  SHALL be the current fetch PC from the PC register.
REQ-005 StallD  input  1  SHALL mean decode cannot accept a new instruction this cycle.
REQ-006 ExcFlush  input  1  SHALL mean an exception or eret redirect: drop in-flight and held instructions.
REQ-007 inst_req  output  1  SHALL be the SRAM-like instruction request.
REQ-008 inst_addr  output  32  SHALL be the request address.
REQ-009 inst_addr_ok  input  1  SHALL mean the request was accepted this cycle.
REQ-010 inst_data_ok  input  1  SHALL mean inst_rdata is valid this cycle.
REQ-011 inst_rdata  input  32  SHALL be the returned instruction word.
REQ-012 PCPlus4F  output  32  SHALL be the sequential next PC fed to the PC register.
REQ-013 StallF  output  1  SHALL hold the PC register when 1.
REQ-014 InstrD, PCD, PCPlus4D  output  32 each  SHALL be the IF/ID register contents.
REQ-015 ValidD  output  1  SHALL mark InstrD as a real instruction.

Function
REQ-016 PCPlus4F SHALL equal PCF+4 modulo 2^32 (0xFFFFFFFC -> 0x00000000), combinationally.
REQ-017 The FSM SHALL have states IDLE, REQ, WAIT, HOLD and CANCEL, with at most one outstanding request.
REQ-018 IDLE SHALL go to REQ unconditionally on the next edge.
REQ-019 In REQ, inst_req SHALL be 1 and inst_addr SHALL equal PCF; inst_req SHALL be 0 in every other state.
REQ-020 REQ SHALL go to WAIT on inst_addr_ok, or to CANCEL if ExcFlush and inst_addr_ok are both 1.
REQ-021 REQ with ExcFlush=1 and inst_addr_ok=0 SHALL stay in REQ, and inst_addr SHALL follow the redirected PCF.
REQ-022 In WAIT with inst_data_ok=1 and no ExcFlush: if StallD=0, the IF/ID register SHALL load {inst_rdata, PCF, PCF+4} with ValidD=1 and the FSM SHALL go to REQ.
REQ-023 Under the same WAIT condition with StallD=1, inst_rdata SHALL be captured in the hold buffer and the FSM SHALL go to HOLD.
REQ-024 HOLD with StallD=0 SHALL load the buffer into IF/ID with ValidD=1 and go to REQ.
REQ-025 ExcFlush in WAIT without inst_data_ok SHALL go to CANCEL.
REQ-026 ExcFlush in WAIT with inst_data_ok=1, or in HOLD, SHALL discard the word and go to REQ.
REQ-027 CANCEL SHALL discard the next inst_data_ok word and then go to REQ.
REQ-028 StallF SHALL be 0 only when a fetch completes into IF/ID this cycle (REQ-022, REQ-024) or when ExcFlush=1; otherwise StallF SHALL be 1.
REQ-029 IF/ID update priority SHALL be, highest first: ExcFlush, then StallD, then load.
- ExcFlush=1: load bubble.
- StallD=1: hold current contents.
- Otherwise, no fetch complete: load bubble.
REQ-030 A bubble SHALL be ValidD=0, InstrD=NOP_INSTR, with PCD/PCPlus4D holding their previous values.
REQ-031 inst_data_ok in IDLE or REQ SHALL be ignored.
REQ-032 Best-case latency SHALL be addr_ok at cycle N, data_ok at cycle N+1, and InstrD valid from cycle N+2.

Reset
REQ-033 Asserting reset SHALL immediately force state IDLE, ValidD=0, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, hold buffer=0 and inst_req=0.
REQ-034 Reset mid-transaction SHALL abandon the request without waiting for data_ok.

Structure
REQ-035 PCSIZE, RESETABLE, the FSM state encodings and NOP_INSTR's default value SHALL live in the shared defines.vh.
REQ-036 The IF/ID register (load/hold/bubble) SHALL be a sub-module named if_id_reg; the FSM and hold buffer SHALL stay in inst_fetch.

Verification
REQ-037 Case: PCF=0xBFC00000 after reset, addr_ok at cycle 1, data_ok with 0x24080001 at cycle 2, StallD=0 -> InstrD=0x24080001, PCD=0xBFC00000, PCPlus4D=0xBFC00004, ValidD=1 from cycle 3; StallF=0 only in cycle 2.
REQ-038 Case: StallD=1 during data_ok with 0x8C090000 and for 3 more cycles -> state HOLD, StallF=1, IF/ID unchanged; IF/ID loads 0x8C090000 the cycle StallD falls.
REQ-039 Case: ExcFlush in WAIT, data_ok with 0xDEADBEEF two cycles later -> word discarded, ValidD=0, and the next request uses the redirected PCF 0xBFC00380.
REQ-040 Case: ExcFlush and addr_ok in the same cycle in REQ -> CANCEL; the following data_ok word is dropped.
REQ-041 Case: PCF=0xFFFFFFFC -> PCPlus4F=0x00000000; reset asserted in WAIT -> IDLE at once, inst_req=0, ValidD=0.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: PC width, reset
// option for the IF/ID register, FSM state encodings and the default bubble.
package inst_fetch_pkg;

   localparam int PCSIZE = 32;

   // 1: IF/ID register clears on reset; 0: IF/ID register built without reset
   localparam bit RESETABLE = 1'b1;

   // Bubble word placed in InstrD whenever ValidD is 0
   localparam logic [PCSIZE-1:0] NOP_INSTR_DEF = 32'h0000_0000;

   // Fetch FSM encodings
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_REQ    = 3'd1,
      S_WAIT   = 3'd2,
      S_HOLD   = 3'd3,
      S_CANCEL = 3'd4
   } fetch_state_t;

   // Contents of the IF/ID pipeline register
   typedef struct packed {
      logic [PCSIZE-1:0] instr;
      logic [PCSIZE-1:0] pc;
      logic [PCSIZE-1:0] pc_plus4;
   } ifid_t;

   // Sequential next PC, wraps modulo 2^PCSIZE
   function automatic logic [PCSIZE-1:0] pc_inc(input logic [PCSIZE-1:0] pc);
      return pc + PCSIZE'(4);
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush and bubble load NOP_INSTR with ValidD=0,
// a stall holds everything, a load captures a completed fetch.
// PC fields keep their previous values across bubbles.
module if_id_reg
   import inst_fetch_pkg::*;
#(
   parameter logic [PCSIZE-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic  clock,
   input  logic  reset,
   input  logic  flush,
   input  logic  stall,
   input  logic  load,
   input  ifid_t din,
   output ifid_t dout,
   output logic  valid
);

   logic rst_int;

   // Reset can be compiled out of this register entirely
   assign rst_int = reset & RESETABLE;

   // Priority: flush, then stall (hold), then load, else bubble
   always_ff @(posedge clock or posedge rst_int) begin
      if (rst_int) begin
         dout  <= '{instr: NOP_INSTR, pc: '0, pc_plus4: '0};
         valid <= 1'b0;
      end else if (flush) begin
         dout.instr <= NOP_INSTR;
         valid      <= 1'b0;
      end else if (!stall) begin
         if (load) begin
            dout  <= din;
            valid <= 1'b1;
         end else begin
            dout.instr <= NOP_INSTR;
            valid      <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: drives a single-outstanding SRAM-like request,
// parks a returned word while decode is stalled, and drops words belonging
// to requests squashed by an exception/eret redirect.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter logic [PCSIZE-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [PCSIZE-1:0] PCF,
   input  logic              StallD,
   input  logic              ExcFlush,
   output logic              inst_req,
   output logic [PCSIZE-1:0] inst_addr,
   input  logic              inst_addr_ok,
   input  logic              inst_data_ok,
   input  logic [PCSIZE-1:0] inst_rdata,
   output logic [PCSIZE-1:0] PCPlus4F,
   output logic              StallF,
   output logic [PCSIZE-1:0] InstrD,
   output logic [PCSIZE-1:0] PCD,
   output logic [PCSIZE-1:0] PCPlus4D,
   output logic              ValidD
);

   fetch_state_t      state, state_nxt;
   logic [PCSIZE-1:0] hold_buf;
   logic              fetch_done;   // a word enters IF/ID this cycle
   logic              hold_cap;     // a word arrives while decode is stalled
   logic              use_buf;      // IF/ID is fed from the hold buffer
   ifid_t             ifid_d, ifid_q;

   assign PCPlus4F  = pc_inc(PCF);
   // Address is only qualified by inst_req; tracking PCF makes a redirect
   // while still in REQ retarget the pending request
   assign inst_addr = PCF;
   // PC advances on a completed fetch or on a redirect
   assign StallF    = ~(fetch_done | ExcFlush);

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   state_nxt = S_REQ;
         S_REQ:    if (inst_addr_ok) state_nxt = ExcFlush ? S_CANCEL : S_WAIT;
         S_WAIT: begin
            if (ExcFlush)          state_nxt = inst_data_ok ? S_REQ : S_CANCEL;
            else if (inst_data_ok) state_nxt = StallD ? S_HOLD : S_REQ;
         end
         S_HOLD:   if (ExcFlush || !StallD) state_nxt = S_REQ;
         // The squashed request still owes one data beat; swallow it
         S_CANCEL: if (inst_data_ok) state_nxt = S_REQ;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Output / datapath control decode
   always_comb begin
      inst_req   = 1'b0;
      fetch_done = 1'b0;
      hold_cap   = 1'b0;
      use_buf    = 1'b0;
      case (state)
         S_REQ:  inst_req = 1'b1;
         S_WAIT: begin
            if (inst_data_ok && !ExcFlush) begin
               if (StallD) hold_cap   = 1'b1;
               else        fetch_done = 1'b1;
            end
         end
         S_HOLD: begin
            if (!ExcFlush && !StallD) begin
               fetch_done = 1'b1;
               use_buf    = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Hold buffer captures the word decode could not take
   always_ff @(posedge clock or posedge reset) begin
      if (reset)         hold_buf <= '0;
      else if (hold_cap) hold_buf <= inst_rdata;
   end

   // PCF is frozen by StallF while a fetch is in flight or parked,
   // so it still names the fetched word when it is loaded
   assign ifid_d = '{instr:    use_buf ? hold_buf : inst_rdata,
                     pc:       PCF,
                     pc_plus4: PCPlus4F};

   if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
      .clock (clock),
      .reset (reset),
      .flush (ExcFlush),
      .stall (StallD),
      .load  (fetch_done),
      .din   (ifid_d),
      .dout  (ifid_q),
      .valid (ValidD)
   );

   assign InstrD   = ifid_q.instr;
   assign PCD      = ifid_q.pc;
   assign PCPlus4D = ifid_q.pc_plus4;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model
// (outstanding/drop/held flags) plus a PC register model driving PCF.
module tb_inst_fetch;

   localparam logic [31:0] NOP = 32'h0000_0000;
   localparam logic [31:0] EXC_VEC = 32'hBFC0_0380;

   logic        clock, reset;
   logic [31:0] PCF, inst_addr, inst_rdata, PCPlus4F, InstrD, PCD, PCPlus4D;
   logic        StallD, ExcFlush, inst_req, inst_addr_ok, inst_data_ok, StallF, ValidD;

   inst_fetch dut (
      .clock(clock), .reset(reset), .PCF(PCF), .StallD(StallD), .ExcFlush(ExcFlush),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .PCPlus4F(PCPlus4F),
      .StallF(StallF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int total = 0;
   int bad = 0;

   // Reference model state
   logic        m_started, m_out, m_drop, m_held;
   logic [31:0] m_hw, m_instr, m_pcd, m_pc4d, pc;
   logic        m_valid;
   // Combinational outputs sampled in the last driven cycle
   logic        s_req, s_stallf;
   logic [31:0] s_addr, s_p4;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_started = 1'b0; m_out = 1'b0; m_drop = 1'b0; m_held = 1'b0; m_hw = '0;
      m_valid = 1'b0; m_instr = NOP; m_pcd = '0; m_pc4d = '0;
   endtask

   // Assert reset mid-cycle, check it takes effect at once, release after an edge
   task automatic do_reset();
      @(negedge clock);
      inst_addr_ok = 1'b0; inst_data_ok = 1'b0; StallD = 1'b0; ExcFlush = 1'b0;
      reset = 1'b1;
      #1;
      chk("rst_inst_req", inst_req, 1'b0);
      chk("rst_ValidD", ValidD, 1'b0);
      chk("rst_InstrD", InstrD, NOP);
      chk("rst_PCD", PCD, 32'h0);
      chk("rst_PCPlus4D", PCPlus4D, 32'h0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      model_reset();
   endtask

   // One clock cycle: drive, compare combinational outputs, advance model,
   // take the edge, compare IF/ID outputs
   task automatic drive(input logic ao, input logic dok, input logic [31:0] rd,
                        input logic sd, input logic ex);
      logic        e_req, comp, e_stf;
      logic [31:0] word;
      @(negedge clock);
      inst_addr_ok = ao; inst_data_ok = dok; inst_rdata = rd; StallD = sd; ExcFlush = ex;
      PCF = pc;
      e_req = m_started && !m_out && !m_held;
      comp  = !ex && !sd && (m_held || (m_out && !m_drop && dok));
      word  = m_held ? m_hw : rd;
      e_stf = !(comp || ex);
      #1;
      chk("inst_req", inst_req, e_req);
      if (e_req) chk("inst_addr", inst_addr, pc);
      chk("StallF", StallF, e_stf);
      chk("PCPlus4F", PCPlus4F, pc + 32'd4);
      s_req = inst_req; s_stallf = StallF; s_addr = inst_addr; s_p4 = PCPlus4F;
      if (ex) begin
         m_valid = 1'b0; m_instr = NOP;
      end else if (!sd) begin
         if (comp) begin
            m_valid = 1'b1; m_instr = word; m_pcd = pc; m_pc4d = pc + 32'd4;
         end else begin
            m_valid = 1'b0; m_instr = NOP;
         end
      end
      if (e_req) begin
         if (ao) begin m_out = 1'b1; m_drop = ex; end
      end else if (m_out && dok) begin
         if (!m_drop && !ex && sd) begin m_held = 1'b1; m_hw = rd; end
         m_out = 1'b0; m_drop = 1'b0;
      end else if (m_out && ex) begin
         m_drop = 1'b1;
      end else if (m_held && (ex || !sd)) begin
         m_held = 1'b0;
      end
      if (ex)          pc = EXC_VEC;
      else if (!e_stf) pc = pc + 32'd4;
      m_started = 1'b1;
      @(posedge clock);
      #1;
      chk("ValidD", ValidD, m_valid);
      chk("InstrD", InstrD, m_instr);
      chk("PCD", PCD, m_pcd);
      chk("PCPlus4D", PCPlus4D, m_pc4d);
   endtask

   initial begin
      reset = 1'b1; PCF = '0; StallD = 1'b0; ExcFlush = 1'b0;
      inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
      model_reset();
      pc = 32'hBFC0_0000;
      do_reset();

      // Best-case fetch after reset
      drive(0, 0, 32'h0, 0, 0);
      chk("t1_idle_req", s_req, 1'b0);
      drive(1, 0, 32'h0, 0, 0);
      chk("t1_req", s_req, 1'b1);
      chk("t1_addr", s_addr, 32'hBFC0_0000);
      chk("t1_stallf_c1", s_stallf, 1'b1);
      drive(0, 1, 32'h2408_0001, 0, 0);
      chk("t1_stallf_c2", s_stallf, 1'b0);
      chk("t1_instr", InstrD, 32'h2408_0001);
      chk("t1_pcd", PCD, 32'hBFC0_0000);
      chk("t1_pc4d", PCPlus4D, 32'hBFC0_0004);
      chk("t1_valid", ValidD, 1'b1);

      // Decode stalled while the word returns: park it, deliver on release
      drive(1, 0, 32'h0, 0, 0);
      chk("t2_addr", s_addr, 32'hBFC0_0004);
      drive(0, 1, 32'h8C09_0000, 1, 0);
      chk("t2_stallf_dok", s_stallf, 1'b1);
      repeat (3) begin
         drive(0, 0, 32'h0, 1, 0);
         chk("t2_hold_stallf", s_stallf, 1'b1);
         chk("t2_hold_req", s_req, 1'b0);
      end
      drive(0, 0, 32'h0, 0, 0);
      chk("t2_release_stallf", s_stallf, 1'b0);
      chk("t2_instr", InstrD, 32'h8C09_0000);
      chk("t2_pcd", PCD, 32'hBFC0_0004);
      chk("t2_valid", ValidD, 1'b1);

      // Redirect while waiting: late word dropped, refetch from vector
      drive(1, 0, 32'h0, 0, 0);
      drive(0, 0, 32'h0, 0, 1);
      chk("t3_flush_stallf", s_stallf, 1'b0);
      drive(0, 0, 32'h0, 0, 0);
      drive(0, 1, 32'hDEAD_BEEF, 0, 0);
      chk("t3_drop_stallf", s_stallf, 1'b1);
      chk("t3_drop_valid", ValidD, 1'b0);
      chk("t3_drop_instr", InstrD, NOP);
      drive(0, 0, 32'h0, 0, 0);
      chk("t3_refetch_req", s_req, 1'b1);
      chk("t3_refetch_addr", s_addr, EXC_VEC);

      // Redirect coincident with address accept
      drive(1, 0, 32'h0, 0, 1);
      drive(0, 1, 32'h1111_1111, 0, 0);
      chk("t4_drop_stallf", s_stallf, 1'b1);
      chk("t4_drop_valid", ValidD, 1'b0);
      drive(0, 0, 32'h0, 0, 0);
      chk("t4_req", s_req, 1'b1);

      // PC wrap, then reset with a request in flight
      pc = 32'hFFFF_FFFC;
      drive(1, 0, 32'h0, 0, 0);
      chk("t5_wrap", s_p4, 32'h0);
      drive(0, 1, 32'hA5A5_A5A5, 0, 0);
      chk("t5_pcd", PCD, 32'hFFFF_FFFC);
      chk("t5_pc4d", PCPlus4D, 32'h0);
      drive(1, 0, 32'h0, 1, 0);
      chk("t5_valid_before_rst", ValidD, 1'b1);
      do_reset();
      drive(0, 0, 32'h0, 0, 0);
      chk("t5_idle_after_rst", s_req, 1'b0);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         if (i % 997 == 996) do_reset();
         drive(1'($urandom % 2), 1'($urandom % 2), $urandom,
               1'(($urandom % 4) == 0), 1'(($urandom % 16) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
